path_test_ctrl: RTL and testbench

Single-clock sequencer that exercises one long_comb_path instance (DUT) against a reference copy of the same path that has relaxed timing. It drives pseudo-random 32-bit vectors, waits a fixed capture latency and compares the two 1-bit results. It counts mismatches and reports pass/fail on a status LED. It sits between the top-level I/O and each per-clock long_comb_path pair, so failing clock rates can be observed on the board.

---
 rtl/path_test_pkg.sv | 21 ++
 rtl/lfsr32.sv | 30 +++
 rtl/path_test_ctrl.sv | 162 ++++++++++++++++
 tb/tb_path_test_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_test_pkg.sv
// Shared types and constants for the long-path test sequencer.
package path_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CHECK,
    DONE
  } state_e;

  // Feedback taps at bits 31, 21, 1 and 0.
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

  // One Fibonacci step: shift left, feedback enters at bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return {q[30:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit pattern generator with synchronous reload and advance-enable.
module lfsr32
  import path_test_pkg::*;
#(
  parameter logic [31:0] RST_VAL = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] lfsr_q;

  // Reload takes priority over advancing so a new run always starts from the seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= RST_VAL;
    end else if (load) begin
      lfsr_q <= seed;
    end else if (adv) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/path_test_ctrl.sv
// Launches pseudo-random vectors into a path under test and its relaxed
// reference, compares the two results after a fixed latency, counts
// mismatches and reports status on an LED.
module path_test_ctrl
  import path_test_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          LAT     = 3,
  parameter int          NUM_VEC = 1024,
  parameter logic [31:0] SEED    = DEFAULT_SEED,
  parameter int          ERR_W   = 16,
  parameter int          BLINK_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] vec_o,
  input  logic              dut_res_i,
  input  logic              ref_res_i,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [31:0]       vec_cnt,
  output logic              led
);

  localparam logic [3:0]  WAIT_INIT = 4'(LAT - 1);
  localparam logic [31:0] NUM_VEC_U = 32'(NUM_VEC);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  vec_q, vec_d;
  logic [3:0]         wait_q, wait_d;
  logic               stop_q, stop_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [31:0]        vcnt_q, vcnt_d;
  logic [BLINK_W-1:0] blink_q;
  logic               led_q, led_d;
  logic               lfsr_load, lfsr_adv;
  logic [31:0]        lfsr_q;
  logic               busy_w;
  logic               wrap_slow, wrap_fast;

  lfsr32 #(
    .RST_VAL(SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .adv  (lfsr_adv),
    .seed (SEED),
    .q    (lfsr_q)
  );

  assign busy_w    = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == CHECK);
  assign wrap_slow = &blink_q;
  assign wrap_fast = &blink_q[BLINK_W-3:0];

  // Sequencer next state, vector launch, latency countdown and result counters.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    wait_d    = wait_q;
    err_d     = err_q;
    vcnt_d    = vcnt_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d     = '0;
          vcnt_d    = '0;
          lfsr_load = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        vec_d    = DATA_W'(lfsr_q);
        lfsr_adv = 1'b1;
        wait_d   = WAIT_INIT;
        // A one-cycle latency has no wait phase at all.
        state_d  = (LAT == 1) ? CHECK : WAIT;
      end
      WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((dut_res_i != ref_res_i) && !(&err_q)) begin
          err_d = err_q + 1'b1;
        end
        vcnt_d = vcnt_q + 32'd1;
        if (stop_q || ((NUM_VEC != 0) && (vcnt_d == NUM_VEC_U))) begin
          state_d = DONE;
        end else begin
          state_d = LAUNCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stop request is sticky only while a run is active, so it is clear again by IDLE.
  always_comb begin
    stop_d = busy_w ? (stop_q | stop) : 1'b0;
  end

  // LED: slow blink while running, solid on for a clean run, fast blink after errors.
  always_comb begin
    led_d = led_q;
    if (busy_w) begin
      if (wrap_slow) led_d = ~led_q;
    end else if ((err_q == '0) && (vcnt_q == '0)) begin
      led_d = 1'b0;
    end else if (err_q == '0) begin
      led_d = 1'b1;
    end else if (wrap_fast) begin
      led_d = ~led_q;
    end
  end

  // Sequencer and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      stop_q  <= 1'b0;
      err_q   <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Free-running blink divider and LED register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= '0;
      led_q   <= 1'b0;
    end else begin
      blink_q <= blink_q + 1'b1;
      led_q   <= led_d;
    end
  end

  assign vec_o   = vec_q;
  assign busy    = busy_w;
  assign done    = (state_q == DONE);
  assign err_cnt = err_q;
  assign vec_cnt = vcnt_q;
  assign led     = led_q;

endmodule

// File: tb/tb_path_test_ctrl.sv
// Bench for path_test_ctrl: three instances with different latency, run
// length and counter width, driven from a table of runs plus random runs.
module tb_path_test_ctrl;

  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam int M_EQ  = 0;  // results always agree
  localparam int M_MID = 1;  // disagree on 2nd and 3rd check only
  localparam int M_RND = 2;  // independent random results
  localparam int M_INV = 3;  // results always disagree

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] start_s = '0;
  logic [2:0] stop_s  = '0;
  logic [2:0] dut_s   = '0;
  logic [2:0] ref_s   = '0;
  wire  [2:0] busy_s, done_s, led_s;
  wire  [2:0][31:0] vec_s, vcnt_s;
  wire  [2:0][15:0] err_s;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  path_test_ctrl #(.DATA_W(32), .LAT(3), .NUM_VEC(4), .SEED(SEED), .ERR_W(16), .BLINK_W(6)) u_main (
    .clk(clk), .rst(rst), .start(start_s[0]), .stop(stop_s[0]), .vec_o(vec_s[0]),
    .dut_res_i(dut_s[0]), .ref_res_i(ref_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .err_cnt(err_s[0]), .vec_cnt(vcnt_s[0]), .led(led_s[0]));

  path_test_ctrl #(.DATA_W(32), .LAT(3), .NUM_VEC(0), .SEED(SEED), .ERR_W(16), .BLINK_W(6)) u_cont (
    .clk(clk), .rst(rst), .start(start_s[1]), .stop(stop_s[1]), .vec_o(vec_s[1]),
    .dut_res_i(dut_s[1]), .ref_res_i(ref_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .err_cnt(err_s[1]), .vec_cnt(vcnt_s[1]), .led(led_s[1]));

  path_test_ctrl #(.DATA_W(32), .LAT(1), .NUM_VEC(20), .SEED(SEED), .ERR_W(4), .BLINK_W(6)) u_sat (
    .clk(clk), .rst(rst), .start(start_s[2]), .stop(stop_s[2]), .vec_o(vec_s[2]),
    .dut_res_i(dut_s[2]), .ref_res_i(ref_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .err_cnt(err_s[2][3:0]), .vec_cnt(vcnt_s[2]), .led(led_s[2]));

  assign err_s[2][15:4] = 12'd0;

  function automatic int lat_of(input int k);
    return (k == 2) ? 1 : 3;
  endfunction
  function automatic int nv_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 0 : 20);
  endfunction
  function automatic int emax_of(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic logic [31:0] model_lfsr(input logic [31:0] q);
    logic fb;
    fb = q[31] ^ q[21] ^ q[1] ^ q[0];
    return {q[30:0], fb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One run on instance k. The reference schedule is arithmetic: vector j is
  // launched on edge 1+j*(LAT+1) and checked on edge (j+1)*(LAT+1).
  task automatic run_one(input int k, input int mode, input int stop_at, input int bstart_at,
                         output int m_err, output int m_vec);
    int lat, nv, emax, c, ph, j;
    bit fin, stop_seen, launched, d, r;
    logic [31:0] lf, cur;
    lat = lat_of(k);
    nv = nv_of(k);
    emax = emax_of(k);
    lf = SEED;
    cur = '0;
    m_err = 0;
    m_vec = 0;
    fin = 1'b0;
    stop_seen = 1'b0;
    launched = 1'b0;
    start_s[k] = 1'b1;
    stop_s[k] = (stop_at == 0);
    tick();
    start_s[k] = 1'b0;
    stop_s[k] = 1'b0;
    chk1("busy_after_start", busy_s[k], 1'b1);
    c = 0;
    while (!fin && c < 2000) begin
      c++;
      ph = (c - 1) % (lat + 1);
      j = (c - 1) / (lat + 1);
      r = 1'($urandom);
      case (mode)
        M_EQ:    d = r;
        M_MID:   d = r ^ ((ph == lat) && (j == 1 || j == 2));
        M_RND:   d = 1'($urandom);
        default: d = ~r;
      endcase
      dut_s[k] = d;
      ref_s[k] = r;
      start_s[k] = (c == bstart_at);
      stop_s[k] = (c == stop_at);
      tick();
      if (ph == 0) begin
        cur = lf;
        lf = model_lfsr(lf);
        launched = 1'b1;
      end
      if (ph == lat) begin
        m_vec++;
        if (d != r && m_err < emax) m_err++;
        if (stop_seen || (nv != 0 && m_vec == nv)) fin = 1'b1;
      end
      if (c == stop_at) stop_seen = 1'b1;
      if (launched) chk32("vec_o", vec_s[k], cur);
      chk1("busy", busy_s[k], !fin);
      chk1("done", done_s[k], fin);
    end
    start_s[k] = 1'b0;
    stop_s[k] = 1'b0;
    n_chk++;
    if (!fin) begin
      n_err++;
      $display("FAIL run_timeout: inst %0d still running after %0d cycles, want done", k, c);
    end
    tick();
    chk1("done_one_cycle", done_s[k], 1'b0);
    chk1("busy_idle", busy_s[k], 1'b0);
    chk32("err_cnt_model", 32'(err_s[k]), m_err);
    chk32("vec_cnt_model", vcnt_s[k], m_vec);
  endtask

  // Idle after a run: solid on when clean, one toggle per 16 cycles otherwise.
  task automatic led_idle(input int k, input int m_err);
    int tog;
    logic prev;
    tick();
    tick();
    if (m_err == 0) begin
      chk1("led_clean", led_s[k], 1'b1);
    end else begin
      tog = 0;
      prev = led_s[k];
      repeat (64) begin
        tick();
        if (led_s[k] !== prev) tog++;
        prev = led_s[k];
      end
      chk32("led_fast_toggles", tog, 4);
    end
  endtask

  typedef struct {
    int k;
    int mode;
    int stop_at;
    int bstart_at;
    int exp_err;
    int exp_vec;
  } run_t;

  run_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int me, mv, tog, k, mode, sa, bs;
    logic prev;
    bit seen;

    tbl[0] = '{0, M_EQ,  -1, -1,  0,  4};
    tbl[1] = '{0, M_MID, -1, -1,  2,  4};
    tbl[2] = '{1, M_EQ,  10, -1,  0,  3};
    tbl[3] = '{2, M_INV, -1, -1, 15, 20};
    tbl[4] = '{0, M_EQ,   0,  5,  0,  4};
    tbl[5] = '{1, M_INV,  5, -1,  2,  2};
    tbl[6] = '{2, M_EQ,   7, -1,  0,  4};
    tbl[7] = '{0, M_EQ,   1, -1,  0,  1};
    tbl[8] = '{1, M_INV,  4, -1,  2,  2};
    tbl[9] = '{2, M_MID, -1,  3,  2, 20};

    // Reset state.
    #3;
    chk1("rst_busy", busy_s[0], 1'b0);
    chk1("rst_done", done_s[0], 1'b0);
    chk32("rst_vec_o", vec_s[0], 32'd0);
    chk32("rst_err_cnt", 32'(err_s[0]), 32'd0);
    chk32("rst_vec_cnt", vcnt_s[0], 32'd0);
    chk1("rst_led", led_s[0], 1'b0);
    #4 rst = 1'b1;

    // Never-run LED stays dark across several blink wraps.
    tog = 0;
    prev = led_s[0];
    repeat (80) begin
      tick();
      if (led_s[0] !== prev) tog++;
      prev = led_s[0];
    end
    chk32("led_never_run_toggles", tog, 0);
    chk1("led_never_run", led_s[0], 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i].k, tbl[i].mode, tbl[i].stop_at, tbl[i].bstart_at, me, mv);
      chk32("tbl_err_cnt", 32'(err_s[tbl[i].k]), tbl[i].exp_err);
      chk32("tbl_vec_cnt", vcnt_s[tbl[i].k], tbl[i].exp_vec);
      led_idle(tbl[i].k, me);
    end

    // Asynchronous reset in the middle of a wait phase.
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    tick();
    tick();
    chk1("pre_rst_busy", busy_s[0], 1'b1);
    #3 rst = 1'b0;
    #1;
    chk32("arst_busy", 32'(busy_s), 32'd0);
    chk32("arst_done", 32'(done_s), 32'd0);
    chk32("arst_led", 32'(led_s), 32'd0);
    chk32("arst_vec_o", vec_s[0], 32'd0);
    chk32("arst_err_cnt_sat", 32'(err_s[2]), 32'd0);
    chk32("arst_vec_cnt_cont", vcnt_s[1], 32'd0);
    #2 rst = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (done_s[0] || busy_s[0]) seen = 1'b1;
    end
    chk1("arst_no_done", seen, 1'b0);
    run_one(0, M_EQ, -1, -1, me, mv);
    chk32("restart_vec_cnt", vcnt_s[0], 32'd4);

    // Slow blink while busy: one toggle per 64 cycles, then stop the run.
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    tog = 0;
    prev = led_s[1];
    repeat (128) begin
      tick();
      if (led_s[1] !== prev) tog++;
      prev = led_s[1];
    end
    chk32("led_busy_toggles", tog, 2);
    stop_s[1] = 1'b1;
    tick();
    stop_s[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (done_s[1]) seen = 1'b1;
    end
    chk1("cont_stop_done", seen, 1'b1);
    chk32("cont_stop_vec_cnt", vcnt_s[1], 32'd33);
    tick();

    // Random runs against the reference schedule.
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 2);
      mode = $urandom_range(0, 3);
      if (k == 1) sa = $urandom_range(1, 40);
      else sa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 30) : -1;
      bs = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 20) : -1;
      run_one(k, mode, sa, bs, me, mv);
      led_idle(k, me);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
